// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and constants for the memory controller
//
// Holds the controller state enum, the access width codes, the width to
// byte-count mapping and the default tag of the memory-mapped IO region.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] WIDTH_BYTE = 2'd0;
    localparam logic [1:0] WIDTH_HALF = 2'd1;
    localparam logic [1:0] WIDTH_WORD = 2'd2;

    // addr[17:16] value that marks the UART / IO window
    localparam logic [1:0] IO_ADDR_TAG_DEFAULT = 2'b11;

    // Width code 3 is not a legal access size; it is serviced as a word.
    function automatic logic [2:0] byte_count(input logic [1:0] width);
        case (width)
            WIDTH_BYTE: return 3'd1;
            WIDTH_HALF: return 3'd2;
            default:    return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// rtl/mem_ctrl_arb.sv - two-way round-robin grant between fetch and load/store
//
// Ports:
//   clk_in, rst_in   clock, asynchronous active-high reset
//   if_req, lsb_req  pending requests
//   take             the controller accepted the offered grant this edge
//   grant_valid      at least one requester is pending
//   grant_lsb        1 = offer goes to load/store, 0 = to fetch
module mem_ctrl_arb (
    input  logic clk_in,
    input  logic rst_in,
    input  logic if_req,
    input  logic lsb_req,
    input  logic take,
    output logic grant_valid,
    output logic grant_lsb
);

    // Reset to "fetch was last" so load/store wins the first tie.
    logic last_lsb;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            last_lsb <= 1'b0;
        end else if (take) begin
            last_lsb <= grant_lsb;
        end
    end

    always_comb begin
        grant_valid = if_req | lsb_req;
        grant_lsb   = lsb_req & (~if_req | ~last_lsb);
    end

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM controller for instruction fetch and load/store
//
// Serialises word fetches and byte/half/word loads and stores onto an 8-bit
// RAM port, one byte per cycle, little-endian.
//
// Build option: MEM_CTRL_IO_STALL_EN - when defined, a store byte aimed at the
// IO window (addr[17:16] == IO_ADDR_TAG) waits while io_buffer_full is high.
//
// Ports:
//   clk_in, rst_in        clock, asynchronous active-high reset
//   rdy_in                global enable; low freezes all state, mem_wr forced 0
//   mem_din/mem_dout      RAM read / write byte
//   mem_a, mem_wr         RAM byte address and write strobe
//   io_buffer_full        UART output buffer full
//   if_req_*/if_reply_*   instruction fetch request and one-cycle reply
//   lsb_req_*/lsb_reply_* load/store request and one-cycle reply
//   flush_signal          pipeline flush; aborts reads, never stores
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [1:0] IO_ADDR_TAG = IO_ADDR_TAG_DEFAULT
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        if_req_en,
    input  logic [31:0] if_req_addr,
    output logic        if_reply_en,
    output logic [31:0] if_reply_data,
    input  logic        lsb_req_en,
    input  logic        lsb_req_type,
    input  logic [31:0] lsb_req_addr,
    input  logic [1:0]  lsb_req_width,
    input  logic [31:0] lsb_req_data,
    output logic        lsb_reply_en,
    output logic [31:0] lsb_reply_data,
    input  logic        flush_signal
);

`ifdef MEM_CTRL_IO_STALL_EN
    localparam bit IO_STALL_EN = 1'b1;
`else
    localparam bit IO_STALL_EN = 1'b0;
`endif

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    // pend: the byte on mem_a has not been issued yet (frozen or IO-stalled)
    logic        pend_q, pend_d;
    logic        t_lsb_q, t_lsb_d;
    logic        t_write_q, t_write_d;
    logic [31:0] t_addr_q, t_addr_d;
    logic [31:0] t_data_q, t_data_d;
    logic [2:0]  t_n_q, t_n_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] mem_a_d;
    logic        mem_wr_d;
    logic [7:0]  mem_dout_d;
    logic        if_reply_en_d, lsb_reply_en_d;
    logic [31:0] if_reply_data_d, lsb_reply_data_d;

    logic        grant_valid, grant_lsb, grant_take;
    logic        issue_now, iss_write, io_blocked;
    logic [31:0] iss_addr;
    logic [7:0]  iss_byte;
    logic [31:0] rdata_n;
    logic [1:0]  next_k;

    mem_ctrl_arb u_arb (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .if_req      (if_req_en),
        .lsb_req     (lsb_req_en),
        .take        (grant_take),
        .grant_valid (grant_valid),
        .grant_lsb   (grant_lsb)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 2'd0;
            pend_q         <= 1'b0;
            t_lsb_q        <= 1'b0;
            t_write_q      <= 1'b0;
            t_addr_q       <= 32'd0;
            t_data_q       <= 32'd0;
            t_n_q          <= 3'd0;
            rdata_q        <= 32'd0;
            mem_a          <= 32'd0;
            mem_wr         <= 1'b0;
            mem_dout       <= 8'd0;
            if_reply_en    <= 1'b0;
            if_reply_data  <= 32'd0;
            lsb_reply_en   <= 1'b0;
            lsb_reply_data <= 32'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            pend_q         <= pend_d;
            t_lsb_q        <= t_lsb_d;
            t_write_q      <= t_write_d;
            t_addr_q       <= t_addr_d;
            t_data_q       <= t_data_d;
            t_n_q          <= t_n_d;
            rdata_q        <= rdata_d;
            mem_a          <= mem_a_d;
            mem_wr         <= mem_wr_d;
            mem_dout       <= mem_dout_d;
            if_reply_en    <= if_reply_en_d;
            if_reply_data  <= if_reply_data_d;
            lsb_reply_en   <= lsb_reply_en_d;
            lsb_reply_data <= lsb_reply_data_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        pend_d           = pend_q;
        t_lsb_d          = t_lsb_q;
        t_write_d        = t_write_q;
        t_addr_d         = t_addr_q;
        t_data_d         = t_data_q;
        t_n_d            = t_n_q;
        rdata_d          = rdata_q;
        mem_a_d          = mem_a;
        mem_wr_d         = mem_wr;
        mem_dout_d       = mem_dout;
        if_reply_en_d    = if_reply_en;
        if_reply_data_d  = if_reply_data;
        lsb_reply_en_d   = lsb_reply_en;
        lsb_reply_data_d = lsb_reply_data;
        grant_take       = 1'b0;
        issue_now        = 1'b0;
        iss_addr         = 32'd0;
        iss_write        = 1'b0;
        iss_byte         = 8'd0;
        io_blocked       = 1'b0;
        rdata_n          = rdata_q;
        next_k           = cnt_q + 2'd1;

        if (!rdy_in) begin
            // Frozen: nothing advances. The byte on the bus is treated as
            // not issued so it is presented again once rdy_in returns.
            mem_wr_d = 1'b0;
            if (state_q == ST_BUSY) begin
                pend_d = 1'b1;
            end
        end else begin
            if_reply_en_d  = 1'b0;
            lsb_reply_en_d = 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    // The edge leaving DONE doubles as a grant edge.
                    state_d    = ST_IDLE;
                    mem_a_d    = 32'd0;
                    mem_wr_d   = 1'b0;
                    mem_dout_d = 8'd0;
                    pend_d     = 1'b0;
                    if (grant_valid && !flush_signal) begin
                        grant_take = 1'b1;
                        state_d    = ST_BUSY;
                        cnt_d      = 2'd0;
                        rdata_d    = 32'd0;
                        t_lsb_d    = grant_lsb;
                        t_write_d  = grant_lsb & lsb_req_type;
                        t_addr_d   = grant_lsb ? lsb_req_addr : if_req_addr;
                        t_data_d   = grant_lsb ? lsb_req_data : 32'd0;
                        t_n_d      = grant_lsb ? byte_count(lsb_req_width) : 3'd4;
                        issue_now  = 1'b1;
                        iss_addr   = grant_lsb ? lsb_req_addr : if_req_addr;
                        iss_write  = grant_lsb & lsb_req_type;
                        iss_byte   = lsb_req_data[7:0];
                    end
                end
                ST_BUSY: begin
                    if (flush_signal && !t_write_q) begin
                        state_d    = ST_IDLE;
                        cnt_d      = 2'd0;
                        pend_d     = 1'b0;
                        mem_a_d    = 32'd0;
                        mem_wr_d   = 1'b0;
                        mem_dout_d = 8'd0;
                    end else if (pend_q) begin
                        // Retry the current byte; no read data is valid yet.
                        issue_now = 1'b1;
                        iss_addr  = mem_a;
                        iss_write = t_write_q;
                        iss_byte  = mem_dout;
                    end else begin
                        if (!t_write_q) begin
                            rdata_n[{cnt_q, 3'b000} +: 8] = mem_din;
                        end
                        rdata_d = rdata_n;
                        if ({1'b0, cnt_q} == t_n_q - 3'd1) begin
                            state_d    = ST_DONE;
                            mem_a_d    = 32'd0;
                            mem_wr_d   = 1'b0;
                            mem_dout_d = 8'd0;
                            if (t_lsb_q) begin
                                lsb_reply_en_d   = 1'b1;
                                lsb_reply_data_d = t_write_q ? 32'd0 : rdata_n;
                            end else begin
                                if_reply_en_d    = 1'b1;
                                if_reply_data_d  = rdata_n;
                            end
                        end else begin
                            cnt_d     = next_k;
                            issue_now = 1'b1;
                            iss_addr  = t_addr_q + {30'd0, next_k};
                            iss_write = t_write_q;
                            iss_byte  = t_data_q[{next_k, 3'b000} +: 8];
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (issue_now) begin
                io_blocked = IO_STALL_EN && iss_write && io_buffer_full &&
                             (iss_addr[17:16] == IO_ADDR_TAG);
                mem_a_d    = iss_addr;
                mem_dout_d = iss_write ? iss_byte : 8'd0;
                if (io_blocked) begin
                    mem_wr_d = 1'b0;
                    pend_d   = 1'b1;
                end else begin
                    mem_wr_d = iss_write;
                    pend_d   = 1'b0;
                end
            end
        end
    end

endmodule
